// File: rtl/hilo_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hilo_ctrl_pkg
// Shared definitions for the HI/LO execute-stage controller:
//   - MD_OP_W and the bit index of each mult/div operation in the one-hot
//     operation vector {0:mult, 1:multu, 2:div, 3:divu}
//   - hilo_state_t, the controller state encoding
//   - md_op_pick(), reduces a multi-hot op vector to its lowest set bit
// -----------------------------------------------------------------------------
package hilo_ctrl_pkg;

    localparam int MD_OP_W     = 4;
    localparam int MD_OP_MULT  = 0;
    localparam int MD_OP_MULTU = 1;
    localparam int MD_OP_DIV   = 2;
    localparam int MD_OP_DIVU  = 3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DIV_REQ   = 2'd1,
        ST_MULT_WAIT = 2'd2,
        ST_DIV_WAIT  = 2'd3
    } hilo_state_t;

    // Keep only the lowest set bit: x & -x in two's complement.
    function automatic logic [MD_OP_W-1:0] md_op_pick(input logic [MD_OP_W-1:0] op);
        return op & (~op + MD_OP_W'(1));
    endfunction

endpackage

// File: rtl/hilo_regfile.sv
// -----------------------------------------------------------------------------
// hilo_regfile
// Architectural HI/LO registers with independent write enables.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset (HI=LO=0)
//   hi_we, hi_wdata     HI write enable / data, written at the next edge
//   lo_we, lo_wdata     LO write enable / data, written at the next edge
//   hi, lo              HI/LO read values
//
// Build option HILO_FWD_EN: when defined, hi/lo forward the value being
// written this cycle so a following mfhi/mflo needs no bubble. Otherwise hi/lo
// are the plain register outputs.
// -----------------------------------------------------------------------------
module hilo_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        hi_we,
    input  logic [31:0] hi_wdata,
    input  logic        lo_we,
    input  logic [31:0] lo_wdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [31:0] hi_q;
    logic [31:0] lo_q;

    // HI/LO are architectural state and must come up as zero, so both
    // registers sit on the reset even though they are just data holders.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (hi_we) hi_q <= hi_wdata;
            if (lo_we) lo_q <= lo_wdata;
        end
    end

`ifdef HILO_FWD_EN
    assign hi = hi_we ? hi_wdata : hi_q;
    assign lo = lo_we ? lo_wdata : lo_q;
`else
    assign hi = hi_q;
    assign lo = lo_q;
`endif

endmodule

// File: rtl/hilo_ctrl.sv
// -----------------------------------------------------------------------------
// hilo_ctrl
// Execute-stage controller around the mult/div unit. Issues mult/multu/div/
// divu requests, stalls execute while an operation is outstanding, commits
// results into HI/LO and services mthi/mtlo. A writeback flush
// (wb_ClrStpJmp_in) discards whatever is in flight.
//
// Parameters:
//   MULT_LAT     cycles from mult request to a valid mult_res_in (1..7)
//   DIV_TIMEOUT  cycles allowed in DIV_WAIT before forced return to IDLE
//                (0 disables the watchdog)
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   exe_valid_in             execute-stage instruction valid
//   exe_md_op_in             one-hot {mult, multu, div, divu}; lowest bit wins
//   exe_mthi_in/exe_mtlo_in  move to HI/LO in execute, data on exe_src_in
//   wb_ClrStpJmp_in          writeback flush
//   div_tready_in            divider can accept a request
//   div_complete_in          divider result valid (single-cycle pulse)
//   div_res_in               {remainder, quotient}
//   mult_res_in              {hi, lo} product
//   md_req_out               request to the mult/div unit (op encoding)
//   stall_out                hold the execute stage
//   busy_out                 controller not in IDLE
//   hi_out, lo_out           HI/LO registers
//
// Build option HILO_FWD_EN (see hilo_regfile): forward same-cycle HI/LO writes.
// -----------------------------------------------------------------------------
module hilo_ctrl
    import hilo_ctrl_pkg::*;
#(
    parameter int MULT_LAT    = 2,
    parameter int DIV_TIMEOUT = 40
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               exe_valid_in,
    input  logic [MD_OP_W-1:0] exe_md_op_in,
    input  logic               exe_mthi_in,
    input  logic               exe_mtlo_in,
    input  logic [31:0]        exe_src_in,
    input  logic               wb_ClrStpJmp_in,
    input  logic               div_tready_in,
    input  logic               div_complete_in,
    input  logic [63:0]        div_res_in,
    input  logic [63:0]        mult_res_in,
    output logic [MD_OP_W-1:0] md_req_out,
    output logic               stall_out,
    output logic               busy_out,
    output logic [31:0]        hi_out,
    output logic [31:0]        lo_out
);

    // One counter serves both waits: down-count for the mult latency,
    // up-count for the divide watchdog.
    localparam int CNT_MAX = (DIV_TIMEOUT > MULT_LAT) ? DIV_TIMEOUT : MULT_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(DIV_TIMEOUT - 1);
    localparam bit               WDOG_EN   = (DIV_TIMEOUT != 0);

    hilo_state_t        state;
    logic [CNT_W-1:0]   cnt;
    logic [MD_OP_W-1:0] op_q;       // divide op held while waiting for tready

    logic [MD_OP_W-1:0] op_sel;
    logic               issue_mult;
    logic               issue_div;
    logic               flush;
    logic               cnt_zero;
    logic               wdog_hit;

    logic               hi_we;
    logic               lo_we;
    logic [31:0]        hi_wdata;
    logic [31:0]        lo_wdata;

    assign op_sel     = md_op_pick(exe_md_op_in);
    assign issue_mult = exe_valid_in && (op_sel[MD_OP_MULT] || op_sel[MD_OP_MULTU]);
    assign issue_div  = exe_valid_in && (op_sel[MD_OP_DIV]  || op_sel[MD_OP_DIVU]);
    assign flush      = wb_ClrStpJmp_in;
    assign cnt_zero   = (cnt == '0);
    assign wdog_hit   = WDOG_EN && (cnt == WDOG_LAST);
    assign busy_out   = (state != ST_IDLE);

    // -------------------------------------------------------------------------
    // State, counter and pending-op register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            op_q  <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
            cnt   <= '0;
            op_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (issue_mult) begin
                        state <= ST_MULT_WAIT;
                        cnt   <= MULT_LOAD;
                    end else if (issue_div) begin
                        op_q  <= op_sel;
                        cnt   <= '0;
                        state <= div_tready_in ? ST_DIV_WAIT : ST_DIV_REQ;
                    end
                end
                ST_DIV_REQ: begin
                    if (div_tready_in) begin
                        state <= ST_DIV_WAIT;
                        cnt   <= '0;
                    end
                end
                ST_MULT_WAIT: begin
                    if (cnt_zero) state <= ST_IDLE;
                    else          cnt   <= cnt - CNT_W'(1);
                end
                ST_DIV_WAIT: begin
                    // cnt counts completed DIV_WAIT cycles; the watchdog fires
                    // on the DIV_TIMEOUT-th consecutive one.
                    if (div_complete_in || wdog_hit) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        op_q  <= '0;
                    end else begin
                        cnt   <= cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Request, stall and HI/LO write decode. These respond in the same cycle
    // as the execute-stage inputs, so they are decoded from state + inputs.
    // -------------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        md_req_out = '0;
        stall_out  = 1'b0;
        hi_we      = 1'b0;
        lo_we      = 1'b0;
        hi_wdata   = '0;
        lo_wdata   = '0;

        // A flush drops the request, the stall and any commit in this cycle.
        if (!flush) begin
            case (state)
                ST_IDLE: begin
                    if (issue_mult) begin
                        md_req_out = op_sel;
                        stall_out  = 1'b1;
                    end else if (issue_div) begin
                        md_req_out = div_tready_in ? op_sel : '0;
                        stall_out  = 1'b1;
                    end else if (exe_valid_in) begin
                        hi_we    = exe_mthi_in;
                        hi_wdata = exe_src_in;
                        lo_we    = exe_mtlo_in;
                        lo_wdata = exe_src_in;
                    end
                end
                ST_DIV_REQ: begin
                    md_req_out = op_q;
                    stall_out  = 1'b1;
                end
                ST_MULT_WAIT: begin
                    stall_out = !cnt_zero;
                    if (cnt_zero) begin
                        hi_we    = 1'b1;
                        lo_we    = 1'b1;
                        hi_wdata = mult_res_in[63:32];
                        lo_wdata = mult_res_in[31:0];
                    end
                end
                ST_DIV_WAIT: begin
                    if (div_complete_in) begin
                        hi_we    = 1'b1;
                        lo_we    = 1'b1;
                        hi_wdata = div_res_in[63:32];
                        lo_wdata = div_res_in[31:0];
                    end else begin
                        stall_out = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    hilo_regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .hi_we    (hi_we),
        .hi_wdata (hi_wdata),
        .lo_we    (lo_we),
        .lo_wdata (lo_wdata),
        .hi       (hi_out),
        .lo       (lo_out)
    );

endmodule

// File: tb/tb_hilo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hilo_ctrl
// Self-checking bench for hilo_ctrl (default parameters MULT_LAT=2,
// DIV_TIMEOUT=40). A table of mult/div vectors is applied in a loop; the
// bench models the external mult/div unit to produce the result bus, pushes
// the expected HI/LO to a scoreboard queue at issue and pops it once the
// controller is back in IDLE. Hand-written sequences cover mthi/mtlo, flush,
// flush against a same-cycle completion, the watchdog and reset mid-divide.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// 1 time unit later.
// -----------------------------------------------------------------------------
module tb_hilo_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        exe_valid_in;
    logic [3:0]  exe_md_op_in;
    logic        exe_mthi_in;
    logic        exe_mtlo_in;
    logic [31:0] exe_src_in;
    logic        wb_ClrStpJmp_in;
    logic        div_tready_in;
    logic        div_complete_in;
    logic [63:0] div_res_in;
    logic [63:0] mult_res_in;
    logic [3:0]  md_req_out;
    logic        stall_out;
    logic        busy_out;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    always #5 clk = ~clk;

    hilo_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .exe_valid_in    (exe_valid_in),
        .exe_md_op_in    (exe_md_op_in),
        .exe_mthi_in     (exe_mthi_in),
        .exe_mtlo_in     (exe_mtlo_in),
        .exe_src_in      (exe_src_in),
        .wb_ClrStpJmp_in (wb_ClrStpJmp_in),
        .div_tready_in   (div_tready_in),
        .div_complete_in (div_complete_in),
        .div_res_in      (div_res_in),
        .mult_res_in     (mult_res_in),
        .md_req_out      (md_req_out),
        .stall_out       (stall_out),
        .busy_out        (busy_out),
        .hi_out          (hi_out),
        .lo_out          (lo_out)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [3:0]  op;          // raw exe_md_op_in
        logic [3:0]  exp_req;     // decoded op expected on md_req_out
        logic [31:0] a;
        logic [31:0] b;
        int          tready_wait; // cycles with div_tready_in low after issue
        int          lat;         // mult: MULT_LAT, div: cycles to complete
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        mthi_too;    // also assert mthi (must be dropped)
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    vec_t        vecs[7];
    exp_t        sb[$];
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference for the external mult/div unit, selected by decoded op.
    function automatic logic [63:0] md_model(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        logic signed [63:0] sp;
        logic signed [31:0] sq;
        logic signed [31:0] sr;
        case (1'b1)
            op[0]: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return sp;
            end
            op[1]: return {32'h0, a} * {32'h0, b};
            op[2]: begin
                sq = $signed(a) / $signed(b);
                sr = $signed(a) % $signed(b);
                return {sr, sq};
            end
            default: return {a % b, a / b};
        endcase
    endfunction

    task automatic idle_inputs();
        exe_valid_in    = 1'b0;
        exe_md_op_in    = '0;
        exe_mthi_in     = 1'b0;
        exe_mtlo_in     = 1'b0;
        exe_src_in      = $urandom;
        wb_ClrStpJmp_in = 1'b0;
        div_tready_in   = 1'b0;
        div_complete_in = 1'b0;
        // Junk on the result buses whenever they are not valid.
        div_res_in      = {$urandom, $urandom};
        mult_res_in     = {$urandom, $urandom};
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input string name, input logic [31:0] hi, input logic [31:0] lo);
        exp_t e;
        e.name = name;
        e.hi   = hi;
        e.lo   = lo;
        sb.push_back(e);
        model_hi = hi;
        model_lo = lo;
    endtask

    task automatic sb_pop_compare();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            checks--;
            e = sb.pop_front();
            check({e.name, " HI"}, 64'(hi_out), 64'(e.hi));
            check({e.name, " LO"}, 64'(lo_out), 64'(e.lo));
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [63:0] res;
        logic        is_div;
        is_div = v.exp_req[2] | v.exp_req[3];
        res    = md_model(v.exp_req, v.a, v.b);

        idle_inputs();
        exe_valid_in  = 1'b1;
        exe_md_op_in  = v.op;
        exe_mthi_in   = v.mthi_too;
        div_tready_in = (v.tready_wait == 0);
        #1;
        check({v.name, " issue req"}, 64'(md_req_out),
              64'((is_div && v.tready_wait != 0) ? 4'b0000 : v.exp_req));
        check({v.name, " issue stall"}, 64'(stall_out), 64'(1'b1));
        sb_push(v.name, v.exp_hi, v.exp_lo);

        if (is_div) begin
            for (int w = 1; w <= v.tready_wait; w++) begin
                next_cycle();
                idle_inputs();
                div_tready_in = (w == v.tready_wait);
                #1;
                check({v.name, " div_req req"}, 64'(md_req_out), 64'(v.exp_req));
                check({v.name, " div_req stall"}, 64'(stall_out), 64'(1'b1));
            end
        end

        for (int c = 1; c <= v.lat; c++) begin
            next_cycle();
            idle_inputs();
            if (c == v.lat) begin
                if (is_div) begin
                    div_complete_in = 1'b1;
                    div_res_in      = res;
                end else begin
                    mult_res_in = res;
                end
            end
            #1;
            check({v.name, " wait stall"}, 64'(stall_out), 64'(c != v.lat));
            check({v.name, " wait req"}, 64'(md_req_out), 64'(4'b0000));
        end

        next_cycle();
        idle_inputs();
        #1;
        check({v.name, " done busy"}, 64'(busy_out), 64'(1'b0));
        sb_pop_compare();
    endtask

    // Start a div with tready high so the controller enters DIV_WAIT next.
    task automatic start_div(input string name);
        idle_inputs();
        exe_valid_in  = 1'b1;
        exe_md_op_in  = 4'b0100;
        div_tready_in = 1'b1;
        #1;
        check({name, " start req"}, 64'(md_req_out), 64'(4'b0100));
    endtask

    task automatic flush_test(input string name, input logic same_cycle_complete);
        start_div(name);
        sb_push(name, model_hi, model_lo);
        for (int c = 1; c <= 10; c++) begin
            next_cycle();
            idle_inputs();
            if (c == 10) begin
                wb_ClrStpJmp_in = 1'b1;
                div_complete_in = same_cycle_complete;
            end
            #1;
            if (c == 10) check({name, " flush req"}, 64'(md_req_out), 64'(4'b0000));
            else         check({name, " wait stall"}, 64'(stall_out), 64'(1'b1));
        end
        next_cycle();
        idle_inputs();
        div_complete_in = !same_cycle_complete;   // late completion is ignored
        #1;
        check({name, " after busy"}, 64'(busy_out), 64'(1'b0));
        check({name, " after stall"}, 64'(stall_out), 64'(1'b0));
        next_cycle();
        idle_inputs();
        #1;
        sb_pop_compare();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: sim time %0t exceeded limit", $time);
        $fatal(1);
    end

    initial begin
        //                name         op       req      a              b          tw lat hi             lo            mthi
        vecs[0] = '{"mult_neg",  4'b0001, 4'b0001, 32'hFFFF_FFFD, 32'd5,          0, 2,  32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
        vecs[1] = '{"multu_big", 4'b0010, 4'b0010, 32'hFFFF_FFFF, 32'd2,          0, 2,  32'h0000_0001, 32'hFFFF_FFFE, 1'b0};
        vecs[2] = '{"divu_wait", 4'b1000, 4'b1000, 32'd10,        32'd3,          3, 33, 32'h0000_0001, 32'h0000_0003, 1'b0};
        vecs[3] = '{"div_neg",   4'b0100, 4'b0100, 32'hFFFF_FFF9, 32'd2,          0, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[4] = '{"multi_hot", 4'b0101, 4'b0001, 32'd6,         32'd7,          0, 2,  32'h0000_0000, 32'h0000_002A, 1'b1};
        vecs[5] = '{"hot_multu", 4'b0110, 4'b0010, 32'h8000_0000, 32'd4,          0, 2,  32'h0000_0002, 32'h0000_0000, 1'b0};
        vecs[6] = '{"hot_div",   4'b1100, 4'b0100, 32'd100,       32'hFFFF_FFF9,  1, 4,  32'h0000_0002, 32'hFFFF_FFF2, 1'b0};

        // Reset state
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("reset md_req", 64'(md_req_out), 64'(4'b0000));
        check("reset stall",  64'(stall_out),  64'(1'b0));
        check("reset busy",   64'(busy_out),   64'(1'b0));
        check("reset hi",     64'(hi_out),     64'(32'h0));
        check("reset lo",     64'(lo_out),     64'(32'h0));
        rst = 1'b0;
        next_cycle();

        foreach (vecs[i]) run_vec(vecs[i]);

        // mthi then mtlo back to back
        idle_inputs();
        exe_valid_in = 1'b1;
        exe_mthi_in  = 1'b1;
        exe_src_in   = 32'hDEAD_BEEF;
        #1;
`ifdef HILO_FWD_EN
        check("mthi same-cycle hi", 64'(hi_out), 64'(32'hDEAD_BEEF));
`else
        check("mthi same-cycle hi", 64'(hi_out), 64'(model_hi));
`endif
        check("mthi stall", 64'(stall_out), 64'(1'b0));
        next_cycle();
        idle_inputs();
        exe_valid_in = 1'b1;
        exe_mtlo_in  = 1'b1;
        exe_src_in   = 32'h1234_5678;
        #1;
        check("mthi hi", 64'(hi_out), 64'(32'hDEAD_BEEF));
`ifdef HILO_FWD_EN
        check("mtlo same-cycle lo", 64'(lo_out), 64'(32'h1234_5678));
`else
        check("mtlo same-cycle lo", 64'(lo_out), 64'(model_lo));
`endif
        next_cycle();
        idle_inputs();
        #1;
        check("mtlo lo", 64'(lo_out), 64'(32'h1234_5678));
        check("mtlo hi kept", 64'(hi_out), 64'(32'hDEAD_BEEF));
        model_hi = 32'hDEAD_BEEF;
        model_lo = 32'h1234_5678;

        flush_test("flush_late_complete", 1'b0);
        flush_test("flush_same_complete", 1'b1);

        // Watchdog: no completion ever arrives; a mthi while busy is ignored.
        start_div("watchdog");
        sb_push("watchdog", model_hi, model_lo);
        for (int c = 1; c <= 40; c++) begin
            next_cycle();
            idle_inputs();
            if (c == 5) begin
                exe_valid_in = 1'b1;
                exe_mthi_in  = 1'b1;
                exe_src_in   = 32'h0BAD_0BAD;
            end
            #1;
            check("watchdog wait stall", 64'(stall_out), 64'(1'b1));
            check("watchdog wait busy",  64'(busy_out),  64'(1'b1));
        end
        next_cycle();
        idle_inputs();
        #1;
        check("watchdog expired busy", 64'(busy_out), 64'(1'b0));
        sb_pop_compare();

        // Reset asserted in the middle of DIV_WAIT
        start_div("reset_mid");
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            idle_inputs();
        end
        #1;
        rst = 1'b1;
        #1;
        check("reset_mid busy",   64'(busy_out),   64'(1'b0));
        check("reset_mid stall",  64'(stall_out),  64'(1'b0));
        check("reset_mid md_req", 64'(md_req_out), 64'(4'b0000));
        check("reset_mid hi",     64'(hi_out),     64'(32'h0));
        check("reset_mid lo",     64'(lo_out),     64'(32'h0));
        next_cycle();
        rst = 1'b0;
        next_cycle();
        check("reset_mid after busy", 64'(busy_out), 64'(1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hilo_ctrl.md
Name: hilo_ctrl

Overview:
- Execute-stage controller sitting around the mult/div unit; downstream consumer of its results and upstream issuer of its requests.
- Issues mult/multu/div/divu requests, sequences the wait for completion, and stalls the pipeline while the operation is outstanding.
- Commits results into the architectural HI/LO registers and services mthi/mtlo writes.
- Honours the writeback flush (wb_ClrStpJmp_in) by discarding in-flight results.

Parameters:
MULT_LAT, 2, cycles from mult request to a valid mult_res_in (1..7)
DIV_TIMEOUT, 40, watchdog cycles in DIV_WAIT before forced return to IDLE (0 = disabled)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
exe_valid_in  in  1  execute-stage instruction valid
exe_md_op_in  in  4  one-hot {0:mult,1:multu,2:div,3:divu}
exe_mthi_in  in  1  mthi in execute
exe_mtlo_in  in  1  mtlo in execute
exe_src_in  in  32  rs value for mthi/mtlo
wb_ClrStpJmp_in  in  1  writeback flush
div_tready_in  in  1  divider ready to accept
div_complete_in  in  1  divider result valid (1-cycle pulse)
div_res_in  in  64  {remainder, quotient}
mult_res_in  in  64  {hi, lo} product
md_req_out  out  4  request to mult/div unit, same encoding as exe_md_op_in
stall_out  out  1  hold execute stage
busy_out  out  1  state != IDLE
hi_out  out  32  HI register
lo_out  out  32  LO register

Behaviour:
- Reset: state IDLE, HI=0, LO=0, counter=0, md_req_out=0, stall_out=0, busy_out=0.
- States: IDLE, DIV_REQ, MULT_WAIT, DIV_WAIT.
- Op decode: multiple bits set in exe_md_op_in → lowest index wins.
- IDLE, valid mult/multu:
  - md_req_out = op for this cycle.
  - Next state MULT_WAIT, counter loaded with MULT_LAT-1.
  - stall_out=1 this cycle.
- IDLE, valid div/divu:
  - div_tready_in=1: md_req_out = op, go DIV_WAIT.
  - div_tready_in=0: go DIV_REQ, no request issued.
  - stall_out=1 either way.
- DIV_REQ: md_req_out = op held in an internal latch; advance to DIV_WAIT on the cycle div_tready_in=1; stall_out=1.
- MULT_WAIT: counter decrements each cycle; stall_out=1 while counter!=0.
- MULT_WAIT, counter==0:
  - Latch HI=mult_res_in[63:32], LO=mult_res_in[31:0].
  - Return to IDLE; stall_out=0 this cycle.
- DIV_WAIT, div_complete_in=1:
  - Latch HI=div_res_in[63:32], LO=div_res_in[31:0].
  - Return to IDLE; stall_out=0 that cycle; otherwise stall_out=1.
- Watchdog: DIV_TIMEOUT consecutive cycles in DIV_WAIT → IDLE, HI/LO unchanged.
- mthi/mtlo: accepted only in IDLE with exe_valid_in and no md op; HI or LO ← exe_src_in at the next edge. If a md op is also present, the md op wins and the move is dropped.
- Flush: wb_ClrStpJmp_in=1 in any state → next state IDLE, no HI/LO write, md_req_out=0, pending op latch cleared. Flush beats a same-cycle completion.
- md_req_out is 0 in every state/cycle not listed above.
- hi_out/lo_out are direct register outputs (one-cycle visibility after write).

Optional Feature:
HILO_FWD_EN:
- Defined: hi_out/lo_out combinationally forward the value being written this cycle (mthi/mtlo, mult commit, div commit), so a following mfhi/mflo reads it with zero bubble.
- Undefined: registered outputs only; the pipeline inserts one bubble after any HI/LO write.

Decomposition:
- Shared package: MD_OP_MULT/MULTU/DIV/DIVU bit indices, state enum typedef (hilo_state_t), MD_OP_W=4.
- One natural sub-module: hilo_regfile (HI/LO registers + write mux + optional forwarding). The FSM stays in hilo_ctrl.

Test Plan:
1. mult, src -3 × 5, MULT_LAT=2 → md_req_out=4'b0001 for 1 cycle, stall 2 cycles, HI=0xFFFFFFFF, LO=0xFFFFFFF1.
2. divu, div_tready_in=0 for 3 cycles then 1, complete after 33 cycles with res {0x1,0x3} → state DIV_REQ 3 cycles, one md_req_out pulse 4'b1000, HI=1, LO=3, stall drops on the complete cycle.
3. div in DIV_WAIT, wb_ClrStpJmp_in pulsed at cycle 10, later div_complete_in → IDLE next cycle, HI/LO unchanged, stall_out=0.
4. mthi 0xDEADBEEF then mtlo 0x12345678 back-to-back → HI/LO updated on successive edges; with HILO_FWD_EN, hi_out=0xDEADBEEF in the same cycle.
5. exe_md_op_in=4'b0101 → treated as mult; md_req_out=4'b0001.
6. rst asserted mid-DIV_WAIT → immediate IDLE, HI=LO=0, all outputs 0.
